// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: round-robin scheduler that time-shares one external
// bit-serial 1101 sequence detector between NREQ serial requesters.
// Each grant opens a FRAME_LEN-bit window. The detector is reset just
// before the window, the granted stream is replayed on det_x, and det_y
// hits are counted.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   req       per-requester request (level)
//   bit_in    per-requester serial data bit
//   hit_clr   synchronous clear of hit_vec
//   det_y     detector match output
//   det_x     serial bit to detector (registered; shows bit k in cycle k+1)
//   det_rst   active-low detector reset; low during the ARB cycle only
//   gnt       one-hot grant; non-zero only while streaming
//   gnt_idx   index of current/last grant
//   busy      high whenever the FSM is not IDLE
//   done      one-cycle pulse in the cycle after REPORT
//   win_hits  hit count of the last completed window; held until next done
//   hit_vec   sticky per-channel "window had hits" flags
//   state_out FSM state encoding
module seq_det_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IW        = 2,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned HCW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] bit_in,
  input  logic            hit_clr,
  input  logic            det_y,
  output logic            det_x,
  output logic            det_rst,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            busy,
  output logic            done,
  output logic [HCW-1:0]  win_hits,
  output logic [NREQ-1:0] hit_vec,
  output logic [1:0]      state_out
);

  localparam int unsigned BCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARB    = 2'b01,
    STREAM = 2'b10,
    REPORT = 2'b11
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [BCW-1:0]  bit_cnt_q;
  logic [HCW-1:0]  hit_cnt_q;
  logic [HCW-1:0]  hit_next_c;
  logic            hit_sample_c;
  logic [IW-1:0]   sel_idx_c;
  logic            sel_found_c;
  logic [IW-1:0]   cand_c;
  logic [NREQ-1:0] hit_vec_c;

  assign state_out = state_q;

  // Round-robin search starting just after the last grant, wrapping mod NREQ.
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = gnt_idx;
    cand_c      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_c = IW'((32'(gnt_idx) + k) % NREQ);
      if (!sel_found_c && req[cand_c]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = cand_c;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ARB;
      ARB:     state_d = sel_found_c ? STREAM : IDLE;
      STREAM:  if (bit_cnt_q == BCW'(FRAME_LEN - 1)) state_d = REPORT;
      REPORT:  state_d = (|req) ? ARB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // det_y is valid from STREAM cycle 1 through REPORT: one cycle for the
  // registered det_x, the detector output follows combinationally.
  always_comb begin
    hit_sample_c = ((state_q == STREAM) && (bit_cnt_q != '0)) || (state_q == REPORT);
    hit_next_c   = hit_cnt_q;
    if (hit_sample_c && det_y && (hit_cnt_q != HCW'(FRAME_LEN)))
      hit_next_c = hit_cnt_q + HCW'(1);
  end

  // Sticky hit flags: clear first so a same-cycle REPORT set wins.
  always_comb begin
    hit_vec_c = hit_clr ? '0 : hit_vec;
    if ((state_q == REPORT) && (hit_next_c != '0))
      hit_vec_c[gnt_idx] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      gnt_idx   <= IW'(NREQ - 1);
      det_rst   <= 1'b1;
      det_x     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_hits  <= '0;
      hit_vec   <= '0;
      bit_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      det_rst <= (state_d != ARB);
      busy    <= (state_d != IDLE);
      done    <= (state_q == REPORT);
      det_x   <= (state_q == STREAM) ? bit_in[gnt_idx] : 1'b0;
      hit_vec <= hit_vec_c;

      if (state_d != STREAM)     gnt <= '0;
      else if (state_q == ARB)   gnt <= NREQ'(1) << sel_idx_c;

      if ((state_q == ARB) && sel_found_c) gnt_idx <= sel_idx_c;

      if (state_q == ARB) begin
        bit_cnt_q <= '0;
        hit_cnt_q <= '0;
      end else begin
        if (state_q == STREAM) bit_cnt_q <= bit_cnt_q + BCW'(1);
        hit_cnt_q <= hit_next_c;
      end

      if (state_q == REPORT) win_hits <= hit_next_c;
    end
  end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Scoreboard bench for seq_det_arbiter: directed windows push expected
// {gnt_idx, win_hits, hit_vec} per done pulse; a negedge monitor pops and
// compares, and also checks grant shape, det_rst timing and det_x replay.
module tb_seq_det_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned FL   = 8;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] hits;
    logic [3:0] vec;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  bit_in = '0;
  logic        hit_clr = 1'b0;
  logic        det_y;
  logic        det_x;
  logic        det_rst;
  logic [3:0]  gnt;
  logic [1:0]  gnt_idx;
  logic        busy;
  logic        done;
  logic [3:0]  win_hits;
  logic [3:0]  hit_vec;
  logic [1:0]  state_out;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [7:0]  pat [NREQ];
  int          bcnt [NREQ];
  int          done_cyc [5];

  seq_det_arbiter #(.NREQ(4), .IW(2), .FRAME_LEN(8), .HCW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .hit_clr(hit_clr),
    .det_y(det_y), .det_x(det_x), .det_rst(det_rst), .gnt(gnt),
    .gnt_idx(gnt_idx), .busy(busy), .done(done), .win_hits(win_hits),
    .hit_vec(hit_vec), .state_out(state_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural Mealy 1101 detector (overlapping), reset by det_rst.
  logic [1:0] ds;
  always @(posedge clk or negedge det_rst) begin
    if (!det_rst) ds <= 2'd0;
    else case (ds)
      2'd0: ds <= det_x ? 2'd1 : 2'd0;
      2'd1: ds <= det_x ? 2'd2 : 2'd0;
      2'd2: ds <= det_x ? 2'd2 : 2'd3;
      default: ds <= det_x ? 2'd1 : 2'd0;
    endcase
  end
  assign det_y = (ds == 2'd3) && det_x;

  // Requesters: a granted channel presents bit k of its pattern in window cycle k.
  initial for (int i = 0; i < NREQ; i++) begin pat[i] = '0; bcnt[i] = 0; end
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        bit_in[i] = pat[i][bcnt[i]];
        bcnt[i]++;
      end else begin
        bit_in[i] = 1'b0;
        bcnt[i] = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] i, input logic [3:0] h, input logic [3:0] v);
    exp_t e;
    e.idx = i; e.hits = h; e.vec = v;
    return e;
  endfunction

  // Monitor: scoreboard pop on done plus per-cycle protocol checks.
  logic [3:0] prev_gnt = '0;
  logic       prev_det_rst = 1'b1;
  logic       exp_x = 1'b0;
  int         run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_gnt = '0; prev_det_rst = 1'b1; exp_x = 1'b0; run = 0;
    end else begin
      chk("det_x_replay", int'(det_x), int'(exp_x));
      if (gnt != 0) begin
        chk("gnt_onehot", int'($onehot(gnt)), 1);
        chk("gnt_in_stream", int'(state_out), 2);
      end
      if (gnt != 0 && prev_gnt == 0) chk("det_rst_before_gnt", int'(prev_det_rst), 0);
      if (gnt == 0 && prev_gnt != 0) chk("window_len", run, FL);
      run = (gnt != 0) ? run + 1 : 0;
      exp_x = |(gnt & bit_in);
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("win_idx", int'(gnt_idx), int'(e.idx));
          chk("win_hits", int'(win_hits), int'(e.hits));
          chk("hit_vec_at_done", int'(hit_vec), int'(e.vec));
        end
      end
      prev_gnt = gnt;
      prev_det_rst = det_rst;
    end
  end

  task automatic wait_gnt(input int idx);
    int n = 0;
    do begin @(negedge clk); n++; end while (gnt == 0 && n < 100);
    if (gnt == 0) chk("gnt_timeout", 0, 1);
    else chk("gnt_value", int'(gnt), 1 << idx);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 100);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_state"}, int'(state_out), 0);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_gnt_idx"}, int'(gnt_idx), 3);
    chk({tag, "_det_rst"}, int'(det_rst), 1);
    chk({tag, "_det_x"}, int'(det_x), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_win_hits"}, int'(win_hits), 0);
    chk({tag, "_hit_vec"}, int'(hit_vec), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst");
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle with no requests.
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_state", int'(state_out), 0);
    end
    chk("idle_gnt", int'(gnt), 0);
    chk("idle_det_rst", int'(det_rst), 1);
    chk("idle_hit_vec", int'(hit_vec), 0);

    // Single hit on channel 1: 1,1,0,1,0,0,0,0.
    pat[1] = 8'b0000_1011;
    exp_q.push_back(mk(2'd1, 4'd1, 4'b0010));
    req = 4'b0010;
    wait_gnt(1);
    req = 4'b0000;
    wait_done();
    repeat (2) @(negedge clk);
    chk("post_window_idle", int'(state_out), 0);
    hit_clr = 1'b1;
    @(negedge clk);
    hit_clr = 1'b0;
    chk("hit_clr_plain", int'(hit_vec), 0);

    // Round robin over all four channels, zero data, 10-cycle cadence.
    do_reset();
    pat[1] = 8'h00;
    for (int w = 0; w < 5; w++) exp_q.push_back(mk(2'(w % 4), 4'd0, 4'b0000));
    req = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      wait_gnt(w % 4);
      if (w == 4) req = 4'b0000;
      wait_done();
      done_cyc[w] = cyc;
    end
    for (int w = 1; w < 5; w++) chk("rr_spacing", done_cyc[w] - done_cyc[w-1], 10);

    // Two overlapping hits on ch0, then ch2 with zeros; ch1/ch3 skipped.
    do_reset();
    pat[0] = 8'b0101_1011;
    pat[2] = 8'h00;
    exp_q.push_back(mk(2'd0, 4'd2, 4'b0001));
    exp_q.push_back(mk(2'd2, 4'd0, 4'b0001));
    req = 4'b0101;
    wait_gnt(0);
    wait_done();
    wait_gnt(2);
    req = 4'b0000;
    wait_done();

    // ch1 hit on its last bit (seen in REPORT) with hit_clr in REPORT.
    pat[1] = 8'b1011_0000;
    exp_q.push_back(mk(2'd1, 4'd1, 4'b0010));
    repeat (2) @(negedge clk);
    req = 4'b0010;
    wait_gnt(1);
    req = 4'b0000;
    repeat (FL) @(posedge clk);
    #1 hit_clr = 1'b1;
    @(negedge clk);
    chk("report_state", int'(state_out), 3);
    chk("report_gnt", int'(gnt), 0);
    @(posedge clk);
    #1 hit_clr = 1'b0;
    wait_done();

    // Request vanishes during ARB: no grant, gnt_idx unchanged.
    repeat (2) @(negedge clk);
    req = 4'b1000;
    @(posedge clk);
    #1 req = 4'b0000;
    @(negedge clk);
    chk("arb_state", int'(state_out), 1);
    chk("arb_det_rst", int'(det_rst), 0);
    @(negedge clk);
    chk("arb_abort_state", int'(state_out), 0);
    chk("arb_abort_gnt", int'(gnt), 0);
    chk("arb_abort_idx", int'(gnt_idx), 1);
    pat[3] = 8'h00;
    exp_q.push_back(mk(2'd3, 4'd0, 4'b0010));
    req = 4'b1001;
    wait_gnt(3);
    req = 4'b0000;
    wait_done();

    // Reset in STREAM cycle 4: immediate clear, no done, restart at ch0.
    repeat (2) @(negedge clk);
    req = 4'b0001;
    wait_gnt(0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_gnt", int'(gnt), 0);
    chk("abort_state", int'(state_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_det_rst", int'(det_rst), 1);
    chk("abort_hit_vec", int'(hit_vec), 0);
    repeat (2) @(negedge clk);
    pat[0] = 8'b0000_1011;
    exp_q.push_back(mk(2'd0, 4'd1, 4'b0001));
    rst = 1'b1;
    wait_gnt(0);
    req = 4'b0000;
    wait_done();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
